// File: rtl/mips_pipe_pkg.sv
// Shared MEM/WB pipeline types: default field widths, the MEM->WB entry record and skid-buffer states.
package mips_pipe_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]     read_data;
    logic [DATA_W_DEF-1:0]     alu_result;
    logic [REG_ADDR_W_DEF-1:0] dest_reg;
    logic                      reg_write;
    logic                      mem_to_reg;
  } mem_wb_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} skid_state_e;

  function automatic int unsigned mem_wb_width(input int unsigned data_w, input int unsigned addr_w);
    return 2 * data_w + addr_w + 2;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: registered in_ready, synchronous flush, data cleared whenever an entry is empty.
module pipe_skid_buf
  import mips_pipe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q, ready_d;
  logic         accept, retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign accept = in_valid & ready_q;
  assign retire = out_ready & (state_q != ST_EMPTY);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d = ST_FULL;
          main_d  = in_data;
        end
        ST_FULL: begin
          if (accept && retire) begin
            main_d = in_data;
          end else if (retire) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end else if (accept) begin
            state_d = ST_SKID;
            skid_d  = in_data;
          end
        end
        ST_SKID: if (retire) begin
          state_d = ST_FULL;
          main_d  = skid_q;
          skid_d  = '0;
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    // Ready is registered from the next state so out_ready never reaches in_ready combinationally.
    ready_d = (state_d != ST_SKID);
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline boundary with valid/ready handshake, 2-entry skid buffer and flush.
// Optional MEM_WB_WBSEL_EN adds the writeback data mux output out_wb_data.
module mem_wb_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_read_data,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [REG_ADDR_W-1:0] in_dest_reg,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_read_data,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [REG_ADDR_W-1:0] out_dest_reg,
  output logic                  out_reg_write,
  output logic                  out_mem_to_reg
`ifdef MEM_WB_WBSEL_EN
 ,output logic [DATA_W-1:0]     out_wb_data
`endif
);

  localparam int unsigned W = mem_wb_width(DATA_W, REG_ADDR_W);

  // Same layout as mem_wb_t, re-declared so non-default widths stay legal.
  typedef struct packed {
    logic [DATA_W-1:0]     read_data;
    logic [DATA_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic                  reg_write;
    logic                  mem_to_reg;
  } entry_t;

  entry_t in_entry, held;

  assign in_entry = '{read_data:  in_read_data,
                      alu_result: in_alu_result,
                      dest_reg:   in_dest_reg,
                      reg_write:  in_reg_write,
                      mem_to_reg: in_mem_to_reg};

  pipe_skid_buf #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (held)
  );

  assign out_read_data  = held.read_data;
  assign out_alu_result = held.alu_result;
  assign out_dest_reg   = held.dest_reg;
  assign out_mem_to_reg = held.mem_to_reg;
  assign out_reg_write  = held.reg_write & out_valid & (held.dest_reg != REG_ADDR_W'(ZERO_REG));

`ifdef MEM_WB_WBSEL_EN
  assign out_wb_data = held.mem_to_reg ? held.read_data : held.alu_result;
`else
  // Writeback mux lives in the WB stage in this build.
`endif

endmodule
